// File: rtl/game_pkg.sv
// Shared types and default constants for the pong game sequencer.
// PAUSE is always part of the enum; it is only reachable in builds with PAUSE_EN.
package game_pkg;

  localparam int SCORE_W = 4;
  localparam int CNT_W   = 8;

  localparam int DEF_TICK_DIV     = 1;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_POINT_FRAMES = 90;
  localparam int DEF_SCORE_WIN    = 9;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    POINT,
    GAME_OVER,
    PAUSE
  } game_state_t;

endpackage

// File: rtl/game_state_ctrl_if.sv
// Control bus between keyboard/ball-miss logic and the game sequencer.
// The sequencer connects through the slave modport; its driver uses the master modport.
interface game_state_ctrl_if;
  import game_pkg::*;

  logic               frame_start;
  logic               start_btn;
  logic               miss_left;
  logic               miss_right;
  logic               pause_btn;
  logic               timing_tick;
  logic               still_graphic;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  logic               serve_dir;
  logic               game_over;
  logic               winner;

  modport master (
    output frame_start, start_btn, miss_left, miss_right, pause_btn,
    input  timing_tick, still_graphic, score_left, score_right,
           serve_dir, game_over, winner
  );

  modport slave (
    input  frame_start, start_btn, miss_left, miss_right, pause_btn,
    output timing_tick, still_graphic, score_left, score_right,
           serve_dir, game_over, winner
  );

endinterface

// File: rtl/game_state_ctrl_frame_tick_gen.sv
// Divides frame_start pulses by TICK_DIV into a one-cycle registered timing_tick.
// While hold is high the divider freezes and no tick is produced.
module frame_tick_gen
  import game_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic hold,
  output logic timing_tick
);

  localparam logic [3:0] LAST = 4'(TICK_DIV - 1);

  logic [3:0] frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      timing_tick <= 1'b0;
    end else begin
      timing_tick <= 1'b0;
      if (frame_start && !hold) begin
        if (frame_cnt == LAST) begin
          frame_cnt   <= '0;
          timing_tick <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Pong game sequencer: IDLE/SERVE/PLAY/POINT/GAME_OVER flow, scores and motion tick.
// Define PAUSE_EN to build the PAUSE state driven by pause_btn edges.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES,
  parameter int SCORE_WIN    = DEF_SCORE_WIN
) (
  input logic               clk,
  input logic               rst,
  game_state_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_SCORE  = SCORE_W'(SCORE_WIN);

  game_state_t        state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [SCORE_W-1:0] score_left, score_left_n;
  logic [SCORE_W-1:0] score_right, score_right_n;
  logic               serve_dir, serve_dir_n;
  logic               still_q, still_n;
  logic               game_over_q, game_over_n;
  logic               winner_q, winner_n;
  logic               start_q, start_edge;
  logic               tick_hold;

  // Edge registers reset high so a button held through reset yields no edge.
  assign start_edge = bus.start_btn & ~start_q;

`ifdef PAUSE_EN
  logic pause_q, pause_edge;
  assign pause_edge = bus.pause_btn & ~pause_q;
  assign tick_hold  = (state_n == PAUSE);
`else
  logic unused_pause;
  assign unused_pause = bus.pause_btn;
  assign tick_hold    = 1'b0;
`endif

  frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk         (clk),
    .rst         (rst),
    .frame_start (bus.frame_start),
    .hold        (tick_hold),
    .timing_tick (bus.timing_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      score_left  <= '0;
      score_right <= '0;
      serve_dir   <= 1'b0;
      still_q     <= 1'b1;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
      start_q     <= 1'b1;
`ifdef PAUSE_EN
      pause_q     <= 1'b1;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      score_left  <= score_left_n;
      score_right <= score_right_n;
      serve_dir   <= serve_dir_n;
      still_q     <= still_n;
      game_over_q <= game_over_n;
      winner_q    <= winner_n;
      start_q     <= bus.start_btn;
`ifdef PAUSE_EN
      pause_q     <= bus.pause_btn;
`endif
    end
  end

  // Outputs are computed from the next state so they are registered with it.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    score_left_n  = score_left;
    score_right_n = score_right;
    serve_dir_n   = serve_dir;
    case (state)
      IDLE, GAME_OVER: begin
        if (start_edge) begin
          score_left_n  = '0;
          score_right_n = '0;
          cnt_n         = SERVE_LOAD;
          state_n       = SERVE;
        end
      end
      SERVE: begin
        if (bus.frame_start) begin
          if (cnt <= CNT_W'(1)) begin
            cnt_n   = '0;
            state_n = PLAY;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
      end
      PLAY: begin
        if (bus.miss_left && bus.miss_right) begin
          cnt_n   = SERVE_LOAD;
          state_n = SERVE;
        end else if (bus.miss_left) begin
          if (score_right < WIN_SCORE) score_right_n = score_right + 1'b1;
          serve_dir_n = 1'b0;
          cnt_n       = POINT_LOAD;
          state_n     = POINT;
        end else if (bus.miss_right) begin
          if (score_left < WIN_SCORE) score_left_n = score_left + 1'b1;
          serve_dir_n = 1'b1;
          cnt_n       = POINT_LOAD;
          state_n     = POINT;
        end
`ifdef PAUSE_EN
        else if (pause_edge) begin
          state_n = PAUSE;
        end
`endif
      end
      POINT: begin
        if (bus.frame_start) begin
          if (cnt <= CNT_W'(1)) begin
            if (score_left == WIN_SCORE || score_right == WIN_SCORE) begin
              cnt_n   = '0;
              state_n = GAME_OVER;
            end else begin
              cnt_n   = SERVE_LOAD;
              state_n = SERVE;
            end
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
      end
`ifdef PAUSE_EN
      PAUSE: begin
        if (pause_edge) state_n = PLAY;
      end
`endif
      default: state_n = IDLE;
    endcase
    still_n     = !(state_n == PLAY || state_n == PAUSE);
    game_over_n = (state_n == GAME_OVER);
    winner_n    = game_over_n && (score_right_n == WIN_SCORE);
  end

  assign bus.still_graphic = still_q;
  assign bus.score_left    = score_left;
  assign bus.score_right   = score_right;
  assign bus.serve_dir     = serve_dir;
  assign bus.game_over     = game_over_q;
  assign bus.winner        = winner_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed game flow plus random play
// against a frame-counting reference model. Define PAUSE_EN to exercise pause.
module tb_game_state_ctrl;
  import game_pkg::*;

  localparam int TICK_DIV     = 2;
  localparam int SERVE_FRAMES = 4;
  localparam int POINT_FRAMES = 3;
  localparam int SCORE_WIN    = 2;

  localparam int PH_IDLE  = 0;
  localparam int PH_SERVE = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_POINT = 3;
  localparam int PH_OVER  = 4;
  localparam int PH_PAUSE = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_state_ctrl_if bus ();

  game_state_ctrl #(
    .TICK_DIV     (TICK_DIV),
    .SERVE_FRAMES (SERVE_FRAMES),
    .POINT_FRAMES (POINT_FRAMES),
    .SCORE_WIN    (SCORE_WIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int tick_count;

  // Reference model: game phase, frames left in the frozen phase, scores, frame tally.
  int ph, m_left, m_right, m_dir, m_remain, m_frames, m_tick;
  bit m_start_prev, m_pause_prev;
  bit sb_lvl = 1'b0;
  bit pb_lvl = 1'b0;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int bump(input int s);
    return (s < SCORE_WIN) ? s + 1 : s;
  endfunction

  task automatic modelReset();
    ph = PH_IDLE; m_left = 0; m_right = 0; m_dir = 0;
    m_remain = 0; m_frames = 0; m_tick = 0;
    m_start_prev = 1'b1; m_pause_prev = 1'b1;
  endtask

  task automatic modelStep(input bit fs, input bit sb, input bit ml, input bit mr, input bit pb);
    bit start_ev;
    start_ev = sb && !m_start_prev;
    m_start_prev = sb;
`ifdef PAUSE_EN
    begin
      bit pause_ev;
      pause_ev = pb && !m_pause_prev;
      if (ph == PH_PLAY && !ml && !mr && pause_ev) ph = PH_PAUSE;
      else if (ph == PH_PAUSE && pause_ev) ph = PH_PLAY;
    end
`endif
    m_pause_prev = pb;
    case (ph)
      PH_IDLE, PH_OVER:
        if (start_ev) begin
          m_left = 0; m_right = 0; m_remain = SERVE_FRAMES; ph = PH_SERVE;
        end
      PH_SERVE:
        if (fs) begin
          m_remain--;
          if (m_remain == 0) ph = PH_PLAY;
        end
      PH_PLAY:
        if (ml && mr) begin
          m_remain = SERVE_FRAMES; ph = PH_SERVE;
        end else if (ml) begin
          m_right = bump(m_right); m_dir = 0; m_remain = POINT_FRAMES; ph = PH_POINT;
        end else if (mr) begin
          m_left = bump(m_left); m_dir = 1; m_remain = POINT_FRAMES; ph = PH_POINT;
        end
      PH_POINT:
        if (fs) begin
          m_remain--;
          if (m_remain == 0) begin
            if (m_left == SCORE_WIN || m_right == SCORE_WIN) ph = PH_OVER;
            else begin m_remain = SERVE_FRAMES; ph = PH_SERVE; end
          end
        end
      default: ;
    endcase
    m_tick = 0;
    if (fs && ph != PH_PAUSE) begin
      m_frames++;
      m_tick = (m_frames % TICK_DIV == 0) ? 1 : 0;
    end
  endtask

  task automatic checkAll(input string where);
    checkOutput({where, ".tick"},  int'(bus.timing_tick),   m_tick);
    checkOutput({where, ".still"}, int'(bus.still_graphic), (ph == PH_PLAY || ph == PH_PAUSE) ? 0 : 1);
    checkOutput({where, ".sl"},    int'(bus.score_left),    m_left);
    checkOutput({where, ".sr"},    int'(bus.score_right),   m_right);
    checkOutput({where, ".dir"},   int'(bus.serve_dir),     m_dir);
    checkOutput({where, ".over"},  int'(bus.game_over),     (ph == PH_OVER) ? 1 : 0);
    if (ph == PH_OVER)
      checkOutput({where, ".winner"}, int'(bus.winner), (m_right == SCORE_WIN) ? 1 : 0);
  endtask

  task automatic applyStimulus(input bit fs, input bit ml, input bit mr);
    @(negedge clk);
    bus.frame_start = fs;
    bus.miss_left   = ml;
    bus.miss_right  = mr;
    bus.start_btn   = sb_lvl;
    bus.pause_btn   = pb_lvl;
    modelStep(fs, sb_lvl, ml, mr, pb_lvl);
    @(posedge clk);
    #1;
    checkAll("cyc");
    tick_count += int'(bus.timing_tick);
    bus.frame_start = 1'b0;
    bus.miss_left   = 1'b0;
    bus.miss_right  = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic pressStart();
    sb_lvl = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    sb_lvl = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    bus.start_btn = sb_lvl;
    bus.pause_btn = pb_lvl;
    modelReset();
    #1;
    checkAll("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.start_btn   = 1'b0;
    bus.miss_left   = 1'b0;
    bus.miss_right  = 1'b0;
    bus.pause_btn   = 1'b0;
    doReset();

    tick_count = 0;
    frames(10);
    checkOutput("idle_ticks", tick_count, 5);

    pressStart();
    frames(3);
    checkOutput("serve_still", int'(bus.still_graphic), 1);
    frames(1);
    checkOutput("play_still", int'(bus.still_graphic), 0);

    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("miss_l_sr", int'(bus.score_right), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("point_repeat_sr", int'(bus.score_right), 1);
    frames(3);
    frames(4);
    checkOutput("replay_play", int'(bus.still_graphic), 0);

    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("both_sl", int'(bus.score_left), 0);
    checkOutput("both_sr", int'(bus.score_right), 1);
    checkOutput("both_still", int'(bus.still_graphic), 1);
    frames(4);

    applyStimulus(1'b0, 1'b1, 1'b0);
    frames(3);
    checkOutput("gover", int'(bus.game_over), 1);
    checkOutput("gover_winner", int'(bus.winner), 1);
    pressStart();
    checkOutput("restart_sr", int'(bus.score_right), 0);
    checkOutput("restart_over", int'(bus.game_over), 0);

    frames(4);
    applyStimulus(1'b0, 1'b0, 1'b1);
    frames(3);
    frames(4);
    checkOutput("midplay_sl", int'(bus.score_left), 1);
    checkOutput("midplay_dir", int'(bus.serve_dir), 1);
    doReset();

    sb_lvl = 1'b1;
    doReset();
    frames(5);
    checkOutput("held_start_still", int'(bus.still_graphic), 1);
    sb_lvl = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

`ifdef PAUSE_EN
    pressStart();
    frames(4);
    pb_lvl = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick_count = 0;
    frames(6);
    checkOutput("pause_ticks", tick_count, 0);
    checkOutput("pause_still", int'(bus.still_graphic), 0);
    pb_lvl = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    pb_lvl = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick_count = 0;
    frames(4);
    checkOutput("resume_ticks", tick_count, 2);
    pb_lvl = 1'b0;
`endif

    doReset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) sb_lvl = ~sb_lvl;
      if ($urandom_range(19) == 0) pb_lvl = ~pb_lvl;
      applyStimulus($urandom_range(2) == 0, $urandom_range(9) == 0, $urandom_range(9) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
